// File: rtl/riscv_pkg.sv
// Shared definitions for the 5-stage RISC-V core: widths, reset PC, NOP encoding
// and the {pc,instr} fetch word used between fetch and decode.
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_word_t;

  localparam fetch_word_t BUBBLE_WORD = '{pc: '0, instr: NOP_INSTR};

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_hold_buffer.sv
// One-entry {pc,instr} buffer that parks the word returning from imem while
// decode is stalled. Clear wins over load.
module fetch_hold_buffer
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        clear,
  input  fetch_word_t load_word,
  output logic        valid,
  output fetch_word_t word
);

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      word  <= BUBBLE_WORD;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      word  <= load_word;
    end
  end

endmodule

// File: rtl/if_id_stage.sv
// Instruction fetch plus IF/ID register: owns the PC, issues one word fetch per
// unstalled cycle to a 1-cycle imem, and survives stalls/flushes without loss.
module if_id_stage
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  input  logic [XLEN-1:0] branch_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            if_id_valid,
  output logic [XLEN-1:0] if_id_pc,
  output logic [XLEN-1:0] if_id_instr
);

  logic [XLEN-1:0] pc_q;
  logic            inflight_valid;
  logic [XLEN-1:0] inflight_pc;

  logic            hold_valid;
  fetch_word_t     hold_word;
  logic            hold_load;
  logic            hold_clear;
  fetch_word_t     inflight_word;

  assign imem_req      = !stall && !flush;
  assign imem_addr     = pc_q;
  assign inflight_word = '{pc: inflight_pc, instr: imem_rdata};

  // The word on imem_rdata is only valid this cycle; park it if decode is stalled.
  assign hold_load  = !flush && stall && inflight_valid && !hold_valid;
  assign hold_clear = flush || (!stall && hold_valid);

  fetch_hold_buffer u_hold (
    .clk       (clk),
    .reset     (reset),
    .load      (hold_load),
    .clear     (hold_clear),
    .load_word (inflight_word),
    .valid     (hold_valid),
    .word      (hold_word)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q           <= RESET_PC;
      inflight_valid <= 1'b0;
      inflight_pc    <= '0;
      if_id_valid    <= 1'b0;
      if_id_pc       <= '0;
      if_id_instr    <= NOP_INSTR;
    end else if (flush) begin
      pc_q           <= word_align(branch_target);
      inflight_valid <= 1'b0;
      if_id_valid    <= 1'b0;
      if_id_pc       <= BUBBLE_WORD.pc;
      if_id_instr    <= BUBBLE_WORD.instr;
    end else if (stall) begin
      inflight_valid <= 1'b0;
    end else begin
      inflight_pc    <= pc_q;
      inflight_valid <= 1'b1;
      pc_q           <= pc_q + XLEN'(4);
      // Oldest word first: a parked word predates whatever is in flight.
      if (hold_valid) begin
        if_id_valid <= 1'b1;
        if_id_pc    <= hold_word.pc;
        if_id_instr <= hold_word.instr;
      end else if (inflight_valid) begin
        if_id_valid <= 1'b1;
        if_id_pc    <= inflight_pc;
        if_id_instr <= imem_rdata;
      end else begin
        if_id_valid <= 1'b0;
        if_id_pc    <= BUBBLE_WORD.pc;
        if_id_instr <= BUBBLE_WORD.instr;
      end
    end
  end

endmodule
